adc_f2f_scheduler: RTL and testbench

- Shares one fixed-to-float converter instance (12-bit unsigned in, IEEE-754 single out, registered output) among NUM_CH ADC sample channels.
- Buffers one sample per channel and picks the next sample round-robin.
- Drives the converter input, waits out its latency, then presents the result tagged with the channel index on a valid/ready output.
- Sits between the ADC capture front-end and the floating-point multiplier stage.

---
 rtl/adc_f2f_scheduler.sv | 148 ++++++++++++++
 tb/tb_adc_f2f_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_f2f_scheduler.sv
// Round-robin scheduler sharing one fixed-to-float converter among ADC channels.
// Optional: define ADC_F2F_ZERO_BYPASS_EN to skip the converter wait for zero samples.
module adc_f2f_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CNV_LAT = 1,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    ch_valid_i,
  input  logic [NUM_CH*12-1:0] ch_data_i,
  output logic [NUM_CH-1:0]    ch_ready_o,
  output logic [11:0]          cnv_fixed_o,
  input  logic [31:0]          cnv_float_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_float_o,
  output logic [CH_W-1:0]      out_ch_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CNV_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] hold_v_q, hold_v_d;
  logic [11:0]       hold_q [NUM_CH];
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   tag_q, tag_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [11:0]       fixed_q, fixed_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_float_q, out_float_d;
  logic              zero_q, zero_d;
  logic [NUM_CH-1:0] acc;
  logic [CH_W-1:0]   win;
  logic              any_v;
  logic              grant;
  int                idx;

  assign ch_ready_o  = rst_i ? '0 : ~hold_v_q;
  assign acc         = ch_valid_i & ch_ready_o;
  assign cnv_fixed_o = fixed_q;
  assign out_valid_o = out_valid_q;
  assign out_float_o = out_float_q;
  assign out_ch_o    = out_ch_q;
  assign busy_o      = (state_q != IDLE);

  // Round-robin pick: nearest set slot after the last grant
  always_comb begin
    win   = last_q;
    any_v = 1'b0;
    idx   = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (hold_v_q[idx]) begin
        win   = CH_W'(idx);
        any_v = 1'b1;
      end
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d     = state_q;
    hold_v_d    = hold_v_q | acc;
    last_d      = last_q;
    tag_d       = tag_q;
    out_ch_d    = out_ch_q;
    cnt_d       = cnt_q;
    fixed_d     = fixed_q;
    out_valid_d = out_valid_q;
    out_float_d = out_float_q;
    zero_d      = zero_q;
    grant       = 1'b0;
    unique case (state_q)
      IDLE: grant = any_v;
      WAIT: begin
        if (cnt_q == '0) begin
          out_float_d = zero_q ? 32'h0 : cnv_float_i;
          out_ch_d    = tag_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          grant       = any_v;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      fixed_d       = hold_q[win];
      hold_v_d[win] = 1'b0;
      last_d        = win;
      tag_d         = win;
      state_d       = WAIT;
`ifdef ADC_F2F_ZERO_BYPASS_EN
      zero_d = (hold_q[win] == 12'h000);
`else
      zero_d = 1'b0;
`endif
      cnt_d = zero_d ? '0 : CNT_W'(CNV_LAT);
    end
  end

  // Sample slots capture on accept
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc[k]) hold_q[k] <= ch_data_i[12*k +: 12];
    end
  end

  // Control and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_v_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      tag_q       <= '0;
      out_ch_q    <= '0;
      cnt_q       <= '0;
      fixed_q     <= '0;
      out_valid_q <= 1'b0;
      out_float_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_v_q    <= hold_v_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      out_ch_q    <= out_ch_d;
      cnt_q       <= cnt_d;
      fixed_q     <= fixed_d;
      out_valid_q <= out_valid_d;
      out_float_q <= out_float_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_adc_f2f_scheduler.sv
// Bench for adc_f2f_scheduler: converter model, timeline reference model,
// directed scenarios followed by randomized traffic.
module tb_adc_f2f_scheduler;

  localparam int NUM_CH  = 4;
  localparam int CNV_LAT = 1;
  localparam int CH_W    = $clog2(NUM_CH);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*12-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_ready;
  logic [11:0]          cnv_fixed;
  logic [31:0]          cnv_float;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_float;
  logic [CH_W-1:0]      out_ch;
  logic                 busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_f2f_scheduler #(.NUM_CH(NUM_CH), .CNV_LAT(CNV_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_ready_o(ch_ready),
    .cnv_fixed_o(cnv_fixed), .cnv_float_i(cnv_float),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_float_o(out_float), .out_ch_o(out_ch), .busy_o(busy)
  );

  function automatic logic [31:0] f2f(input logic [11:0] x);
    int p;
    logic [31:0] m;
    if (x == 12'h000) return 32'h0;
    p = 11;
    while (!x[p]) p--;
    m = (32'(x) << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Converter model: registered, CNV_LAT edges deep
  logic [31:0] cpipe [CNV_LAT];
  always_ff @(posedge clk) begin
    cpipe[0] <= f2f(cnv_fixed);
    for (int i = 1; i < CNV_LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign cnv_float = cpipe[CNV_LAT-1];

  // Reference model: slots, an in-flight conversion with a due cycle,
  // and one presented result.
  bit          slot_v [NUM_CH];
  logic [11:0] slot_d [NUM_CH];
  int          m_last;
  bit          m_infl;
  int          m_due;
  int          m_tag;
  logic [11:0] m_fixed;
  bit          m_ov;
  logic [31:0] m_of;
  int          m_och;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit [NUM_CH-1:0] rdy;
    bit g;
    bit found;
    int w;
    cyc++;
    if (rst) begin
      foreach (slot_v[k]) slot_v[k] = 0;
      m_last = NUM_CH - 1;
      m_infl = 0; m_ov = 0; m_of = 0; m_och = 0;
      m_fixed = 0; m_tag = 0;
      return;
    end
    for (int k = 0; k < NUM_CH; k++) rdy[k] = !slot_v[k];
    g = 0;
    if (m_infl) begin
      if (cyc == m_due) begin
        m_ov = 1; m_of = f2f(m_fixed); m_och = m_tag; m_infl = 0;
      end
    end else if (m_ov) begin
      if (out_ready) begin m_ov = 0; g = 1; end
    end else begin
      g = 1;
    end
    if (g) begin
      found = 0; w = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
        if (!found && slot_v[(m_last + i) % NUM_CH]) begin
          found = 1; w = (m_last + i) % NUM_CH;
        end
      end
      if (found) begin
        slot_v[w] = 0;
        m_fixed = slot_d[w];
        m_last = w; m_tag = w; m_infl = 1;
        m_due = cyc + CNV_LAT + 1;
`ifdef ADC_F2F_ZERO_BYPASS_EN
        if (m_fixed == 12'h000) m_due = cyc + 1;
`endif
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_valid[k] && rdy[k]) begin
        slot_v[k] = 1; slot_d[k] = ch_data[12*k +: 12];
      end
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] er;
    for (int k = 0; k < NUM_CH; k++) er[k] = !rst && !slot_v[k];
    #1 check("ready", 32'(ch_ready), 32'(er));
    @(posedge clk);
    model_edge();
    #1;
    check("valid", 32'(out_valid), 32'(m_ov));
    check("float", out_float, m_of);
    check("ch", 32'(out_ch), 32'(m_och));
    check("fixed", 32'(cnv_fixed), 32'(m_fixed));
    check("busy", 32'(busy), 32'(m_infl || m_ov));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ch_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic latency(input string tag, input int ch,
                         input logic [11:0] d, input int exp);
    int n;
    out_ready = 1'b1;
    ch_valid = '0;
    ch_valid[ch] = 1'b1;
    ch_data[12*ch +: 12] = d;
    step();
    ch_valid = '0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check(tag, 32'(n), 32'(exp));
    idle(3);
  endtask

  initial begin
    rst = 1'b1; ch_valid = '0; ch_data = '0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    idle(2);

    latency("lat_ch2", 2, 12'h800, CNV_LAT + 2);
    check("lat_float", out_float, 32'h4500_0000);

    ch_data  = {12'h000, 12'h800, 12'hFFF, 12'h001};
    ch_valid = 4'hF;
    step();
    idle(20);

    ch_valid = 4'b1001;
    for (int i = 0; i < 30; i++) begin
      ch_data = {12'($urandom), 12'h0, 12'h0, 12'($urandom)};
      step();
    end
    idle(6);

    ch_valid = 4'b0010; ch_data = {4{12'h5A5}};
    step();
    ch_valid = '0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    out_ready = 1'b0;
    ch_valid = 4'hF; ch_data = {12'h111, 12'h222, 12'h333, 12'h444};
    for (int i = 0; i < 10; i++) step();
    out_ready = 1'b1;
    idle(25);

    ch_valid = 4'b0010; ch_data = {4{12'h123}};
    step();
    ch_valid = '0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    idle(6);

`ifdef ADC_F2F_ZERO_BYPASS_EN
    latency("lat_zero", 0, 12'h000, 2);
`else
    latency("lat_zero", 0, 12'h000, CNV_LAT + 2);
`endif

    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(199, 0) == 0);
      out_ready = ($urandom_range(9, 0) < 7);
      ch_valid  = NUM_CH'($urandom);
      for (int k = 0; k < NUM_CH; k++)
        ch_data[12*k +: 12] = ($urandom_range(3, 0) == 0) ? 12'h000
                                                         : 12'($urandom);
      step();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
